junction_phase_scheduler: RTL
=============================

# junction_phase_scheduler

Actuated phase scheduler for a three-road junction. It shares the single right-of-way among roads 0..2 using round-robin arbitration and sequences each service through green, yellow and all-red clearance with cycle-count timers. It drives per-road red/yellow/green lamps and sits above the per-road lamp drivers, replacing ad-hoc spot-sensor state logic with a timed, fair schedule.

## Interface
- GREEN_MIN, 8: minimum green cycles, ≥1.
- GREEN_MAX, 32: green cycles after which a competing request forces yellow; ≥GREEN_MIN.
- YELLOW_T, 3: yellow cycles, ≥1.
- ALLRED_T, 2: all-red clearance cycles, ≥1.
- WALK_T, 6: pedestrian walk cycles, ≥1; used only with the macro.
- TW, 8: timer width; all timing parameters fit in TW bits.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  3  per-road vehicle presence, level-sensitive, sampled every cycle.
- ped_req  in  1  pedestrian push-button pulse; macro only.
- red  out  3  red lamp per road.
- yellow  out  3  yellow lamp per road.
- green  out  3  green lamp per road.
- active_road  out  2  road holding right-of-way; 0..2.
- phase  out  3  current phase code from the package.
- walk  out  1  walk lamp; macro only.

## Operation
- Phases: IDLE, GREEN, YELLOW, CLEAR, WALK (macro).
- Reset, asynchronous, immediate even mid-phase:
  - phase=IDLE, red=3'b111, yellow=0, green=0, active_road=0, walk=0.
  - Timer=0; round-robin pointer last=2, so road 0 wins first; ped latch cleared.
- Timer: counts cycles in the current phase and clears on every phase entry. "Elapsed" = timer+1.
- IDLE:
  - All red.
  - Any req bit → GREEN for the arbiter winner.
  - Else, with the macro, ped pending → WALK.
  - Else stay.
- Arbitration: search from (last+1) mod 3 upward with wrap; first set req bit wins. On GREEN entry, last and active_road take the winner.
- GREEN: green[active_road]=1; other roads red. Competing = req with the active bit masked, OR ped pending (macro).
  - Gap-out: go to YELLOW when elapsed ≥ GREEN_MIN, competing, and req[active_road]=0.
  - Max-out: go to YELLOW when elapsed ≥ GREEN_MAX and competing, regardless of own req.
  - No competing request: rest in green indefinitely. The timer saturates at all-ones and does not wrap.
- YELLOW: yellow[active_road]=1, others red. Exactly YELLOW_T cycles, then CLEAR.
- CLEAR: all red. Exactly ALLRED_T cycles, then exit in this priority:
  1. ped pending → WALK (macro);
  2. any req → GREEN for the winner; the road just served may win only if no other road requests;
  3. otherwise IDLE.
- WALK: all red, walk=1. Exactly WALK_T cycles; the ped latch clears on WALK entry. Then arbitrate as on CLEAR exit, skipping the ped check.
- Ped latch: set by ped_req in any phase. A ped_req in the same cycle as the clear on WALK entry re-sets the latch; set wins.
- Invariants:
  - At most one bit of green|yellow is set.
  - For each road, exactly one of red/yellow/green is set.
  - active_road never equals 3.

## Timing
- All outputs are registered and decoded from next-phase, so lamps change on the same edge as phase. There is no output lag.
- req is sampled at the edge where the decision is taken. A req edge is visible in phase at the following edge.
- Lamp durations in cycles:
  - green ≥ GREEN_MIN;
  - yellow = YELLOW_T exactly;
  - all-red between two greens ≥ ALLRED_T.
- IDLE→GREEN latency: one edge after req is seen high.
- Minimum road-switch time: GREEN_MIN+YELLOW_T+ALLRED_T cycles.
- If req drops during YELLOW or CLEAR, the service is not aborted.
- If every req drops at the CLEAR exit, go to IDLE.

## Configuration
- PED_WALK_EN defined:
  - ped_req, walk, the ped latch and the WALK phase exist;
  - ped pending counts as a competing request in GREEN.
- PED_WALK_EN undefined:
  - no ped_req or walk ports and no WALK phase;
  - WALK_T is unused;
  - the phase encoding is unchanged, and the WALK code is never produced.

## Structure
- Package junction_pkg holds:
  - the phase enum: IDLE=0, GREEN=1, YELLOW=2, CLEAR=3, WALK=4;
  - the road index typedef (2 bits) and NUM_ROADS=3;
  - default timing constants.
- Sub-module rr_arbiter3 is combinational: inputs req[2:0] and last[1:0], outputs winner[1:0] and any.

## Test plan
- Reset, then req=3'b001 held: IDLE; green=3'b001 one edge after req; rests in green with red=3'b110 for 100 cycles.
- Road 0 green with req=3'b011 held: max-out at 32 green cycles; then yellow=3'b001 for 3 cycles; all red for 2 cycles; green=3'b010.
- Gap-out: road 0 green, req[0] dropped at cycle 5, req[2]=1: yellow starts after exactly 8 green cycles; road 2 served next.
- Fairness: req=3'b111 held: service order 0,1,2,0,1; each green lasts 32 cycles.
- Async reset_n low mid-YELLOW: outputs go to all-red and IDLE immediately without waiting for a clk edge; after release with req=3'b100, road 0 is skipped and road 2 is served.
- PED_WALK_EN: road 1 green, ped_req pulse at cycle 2 with no vehicle requests: yellow after 8 green cycles, 2 all-red cycles, walk=1 for 6 cycles, then IDLE. A second ped_req on the WALK entry edge produces a second walk.

Source files
------------

// File: rtl/junction_pkg.sv
// ============================================================================
// Module : junction_pkg
// Desc   : Shared phase encoding, road index type and default timing
//          for the three-road junction scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package junction_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    CLEAR  = 3'd3,
    WALK   = 3'd4
  } phase_e;

  typedef logic [1:0] road_t;

  localparam int NUM_ROADS      = 3;
  localparam int DEF_GREEN_MIN  = 8;
  localparam int DEF_GREEN_MAX  = 32;
  localparam int DEF_YELLOW_T   = 3;
  localparam int DEF_ALLRED_T   = 2;
  localparam int DEF_WALK_T     = 6;
  localparam int DEF_TW         = 8;

  function automatic logic [NUM_ROADS-1:0] road_onehot(input road_t r);
    logic [NUM_ROADS-1:0] oh;
    case (r)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter3.sv
// ============================================================================
// Module : rr_arbiter3
// Desc   : Combinational three-way round-robin arbiter; the search starts
//          just after the last served road, so that road is considered last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter3
  import junction_pkg::*;
(
  input  logic [2:0] req,
  input  road_t      last,
  output road_t      winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      winner = 2'd1;
        else if (req[2]) winner = 2'd2;
        else             winner = 2'd0;
      end
      2'd1: begin
        if (req[2])      winner = 2'd2;
        else if (req[0]) winner = 2'd0;
        else             winner = 2'd1;
      end
      default: begin
        if (req[0])      winner = 2'd0;
        else if (req[1]) winner = 2'd1;
        else             winner = 2'd2;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/junction_phase_scheduler.sv
// ============================================================================
// Module : junction_phase_scheduler
// Desc   : Round-robin green/yellow/all-red phase sequencer for a three-road
//          junction. Optional pedestrian walk phase under PED_WALK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module junction_phase_scheduler
  import junction_pkg::*;
#(
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int GREEN_MAX = DEF_GREEN_MAX,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int WALK_T    = DEF_WALK_T,
  parameter int TW        = DEF_TW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_ROADS-1:0] req,
`ifdef PED_WALK_EN
  input  logic                 ped_req,
  output logic                 walk,
`endif
  output logic [NUM_ROADS-1:0] red,
  output logic [NUM_ROADS-1:0] yellow,
  output logic [NUM_ROADS-1:0] green,
  output logic [1:0]           active_road,
  output logic [2:0]           phase
);

  phase_e               r_phase, w_phase_nxt;
  logic [TW-1:0]        r_timer;
  road_t                r_last, r_active, w_active_nxt, w_win;
  logic                 w_any, w_ped_pend, w_competing, w_own_req;
  logic                 w_min_done, w_max_done;
  logic [NUM_ROADS-1:0] r_red, r_yellow, r_green;
  logic [NUM_ROADS-1:0] w_oh_nxt, w_green_nxt, w_yellow_nxt;

  rr_arbiter3 u_arb (
    .req    (req),
    .last   (r_last),
    .winner (w_win),
    .any    (w_any)
  );

`ifdef PED_WALK_EN
  logic r_ped, r_walk, w_walk_entry;

  assign w_ped_pend   = r_ped;
  assign w_walk_entry = (w_phase_nxt == WALK) && (r_phase != WALK);
  assign walk         = r_walk;

  // A press on the walk-entry edge must survive the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ped  <= 1'b0;
      r_walk <= 1'b0;
    end else begin
      r_ped  <= ped_req | (r_ped & ~w_walk_entry);
      r_walk <= (w_phase_nxt == WALK);
    end
  end
`else
  localparam int c_unused_walk_t = WALK_T;
  assign w_ped_pend = 1'b0;
`endif

  // Timer holds elapsed-1, so thresholds compare against T-1.
  assign w_own_req   = |(req & road_onehot(r_active));
  assign w_competing = (|(req & ~road_onehot(r_active))) | w_ped_pend;
  assign w_min_done  = (r_timer >= TW'(GREEN_MIN - 1));
  assign w_max_done  = (r_timer >= TW'(GREEN_MAX - 1));

  always_comb begin
    w_phase_nxt  = r_phase;
    w_active_nxt = r_active;
    case (r_phase)
      IDLE: begin
        if (w_any) begin
          w_phase_nxt  = GREEN;
          w_active_nxt = w_win;
        end
`ifdef PED_WALK_EN
        else if (w_ped_pend) w_phase_nxt = WALK;
`endif
      end
      GREEN: begin
        if (w_competing && ((w_min_done && !w_own_req) || w_max_done))
          w_phase_nxt = YELLOW;
      end
      YELLOW: begin
        if (r_timer == TW'(YELLOW_T - 1)) w_phase_nxt = CLEAR;
      end
      CLEAR: begin
        if (r_timer == TW'(ALLRED_T - 1)) begin
          if (w_ped_pend) begin
`ifdef PED_WALK_EN
            w_phase_nxt = WALK;
`endif
          end else if (w_any) begin
            w_phase_nxt  = GREEN;
            w_active_nxt = w_win;
          end else begin
            w_phase_nxt = IDLE;
          end
        end
      end
`ifdef PED_WALK_EN
      WALK: begin
        if (r_timer == TW'(WALK_T - 1)) begin
          if (w_any) begin
            w_phase_nxt  = GREEN;
            w_active_nxt = w_win;
          end else begin
            w_phase_nxt = IDLE;
          end
        end
      end
`endif
      default: w_phase_nxt = IDLE;
    endcase
  end

  // Lamps are decoded from the next phase so they switch with it.
  assign w_oh_nxt     = road_onehot(w_active_nxt);
  assign w_green_nxt  = (w_phase_nxt == GREEN)  ? w_oh_nxt : '0;
  assign w_yellow_nxt = (w_phase_nxt == YELLOW) ? w_oh_nxt : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase  <= IDLE;
      r_timer  <= '0;
      r_last   <= 2'd2;
      r_active <= 2'd0;
      r_red    <= '1;
      r_yellow <= '0;
      r_green  <= '0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_active <= w_active_nxt;
      if (w_phase_nxt != r_phase)      r_timer <= '0;
      else if (r_timer != {TW{1'b1}})  r_timer <= r_timer + 1'b1;
      if ((w_phase_nxt == GREEN) && (r_phase != GREEN)) r_last <= w_active_nxt;
      r_green  <= w_green_nxt;
      r_yellow <= w_yellow_nxt;
      r_red    <= ~(w_green_nxt | w_yellow_nxt);
    end
  end

  assign red         = r_red;
  assign yellow      = r_yellow;
  assign green       = r_green;
  assign active_road = r_active;
  assign phase       = r_phase;

endmodule

`default_nettype wire
